// File: rtl/serial_compare_ctrl_if.sv
// Request/result bundle between a requesting datapath (master) and the
// serial comparator sequencer (slave).
interface serial_compare_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             greater;
  logic             less;
  logic             equal;

  modport master (
    output start, a_in, b_in,
    input  busy, done, greater, less, equal
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, greater, less, equal
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// Serial MSB-first unsigned comparator built from one shared one_bit_full_comparator slice.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN finishes at the first differing bit.
module one_bit_full_comparator (
  input  logic a,
  input  logic b,
  input  logic prev_greater,
  input  logic prev_less,
  input  logic prev_equal,
  output logic greater,
  output logic less,
  output logic equal
);
  // A decision made at a more significant bit is sticky.
  assign greater = prev_greater | (prev_equal & a & ~b);
  assign less    = prev_less    | (prev_equal & ~a & b);
  assign equal   = prev_equal   & ~(a ^ b);
endmodule

module serial_compare_ctrl #(
  parameter  int WIDTH = 8,
  localparam int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_compare_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [IDXW-1:0]   r_idx;
  logic              r_g;
  logic              r_l;
  logic              r_e;
  logic              r_busy;
  logic              r_done;
  logic              r_greater;
  logic              r_less;
  logic              r_equal;

  logic              w_g;
  logic              w_l;
  logic              w_e;
  logic              w_last;

  one_bit_full_comparator u_slice (
    .a            (r_a[r_idx]),
    .b            (r_b[r_idx]),
    .prev_greater (r_g),
    .prev_less    (r_l),
    .prev_equal   (r_e),
    .greater      (w_g),
    .less         (w_l),
    .equal        (w_e)
  );

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign w_last = (r_idx == '0) || !w_e;
`else
  assign w_last = (r_idx == '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_g       <= 1'b0;
      r_l       <= 1'b0;
      r_e       <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_greater <= 1'b0;
      r_less    <= 1'b0;
      r_equal   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a_in;
            r_b     <= bus.b_in;
            r_idx   <= IDXW'(WIDTH - 1);
            r_g     <= 1'b0;
            r_l     <= 1'b0;
            r_e     <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_g <= w_g;
          r_l <= w_l;
          r_e <= w_e;
          if (w_last) begin
            r_greater <= w_g;
            r_less    <= w_l;
            r_equal   <= w_e;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_idx <= r_idx - IDXW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.greater = r_greater;
  assign bus.less    = r_less;
  assign bus.equal   = r_equal;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl: stimulus pushes expected result and
// done cycle, a negedge monitor pops and compares on every done pulse.
module tb_serial_compare_ctrl;
  localparam int W = 8;
  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_compare_ctrl_if #(.WIDTH(W)) bus ();

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  gle;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [2:0]  held = 3'b000;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: done cycle and result checked against the scoreboard;
  // between dones the result outputs must hold the last reported value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          mon_e = q.pop_front();
          chk("done_cycle", cyc, mon_e.cyc);
          chk("result_gle", {29'd0, bus.greater, bus.less, bus.equal}, {29'd0, mon_e.gle});
          chk("busy_at_done", {31'd0, bus.busy}, 32'd1);
          held = mon_e.gle;
        end
      end else begin
        chk("result_hold", {29'd0, bus.greater, bus.less, bus.equal}, {29'd0, held});
      end
    end
  end

  // Called aligned at posedge+2; returns aligned after DONE->IDLE so the next
  // call is accepted back-to-back (one compare per W+2 cycles).
  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input logic [2:0] gle,
                         input int unsigned lat_def, input int unsigned lat_early);
    int unsigned k;
    int unsigned lat;
    lat = EARLY ? lat_early : lat_def;
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    k = cyc + 1;
    q.push_back('{gle, k + lat});
    @(posedge clk); #2;
    bus.start = 1'b0;
    bus.a_in  = ~a;
    bus.b_in  = ~b;
    chk("busy_in_run", {31'd0, bus.busy}, 32'd1);
    while (cyc < k + lat + 1) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic hold_start_test();
    int unsigned k;
    int unsigned k2;
    int unsigned lat1;
    int unsigned lat2;
    lat1 = EARLY ? 3 : 8;   // 0x12 vs 0x34 first differ at bit 5
    lat2 = EARLY ? 1 : 8;   // 0xC0 vs 0x40 differ at bit 7
    bus.start = 1'b1;
    bus.a_in  = 8'h12;
    bus.b_in  = 8'h34;
    k  = cyc + 1;
    k2 = k + lat1 + 2;
    q.push_back('{LT, k + lat1});
    q.push_back('{GT, k2 + lat2});
    while (cyc < k2 - 1) begin
      @(posedge clk); #2;
      if (cyc == k2 - 1) begin
        bus.a_in = 8'hC0;
        bus.b_in = 8'h40;
      end else begin
        bus.a_in = 8'($urandom);
        bus.b_in = 8'($urandom);
      end
    end
    @(posedge clk); #2;
    bus.start = 1'b0;
    bus.a_in  = 8'h00;
    bus.b_in  = 8'hFF;
    while (cyc < k2 + lat2 + 1) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic reset_abort_test();
    int unsigned k;
    bus.start = 1'b1;
    bus.a_in  = 8'h55;
    bus.b_in  = 8'h55;
    k = cyc + 1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    while (cyc < k + 3) begin
      @(posedge clk); #2;
    end
    rst_n = 1'b0;
    q.delete();
    held = 3'b000;
    @(posedge clk); #1;
    chk("abort_outputs", {27'd0, bus.busy, bus.done, bus.greater, bus.less, bus.equal}, 32'd0);
    #1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_cmp(8'h01, 8'h00, GT, 8, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {27'd0, bus.busy, bus.done, bus.greater, bus.less, bus.equal}, 32'd0);
    #1;
    rst_n = 1'b1;

    run_cmp(8'hA5, 8'hA5, EQ, 8, 8);
    run_cmp(8'h80, 8'h7F, GT, 8, 1);
    run_cmp(8'h3C, 8'h3D, LT, 8, 8);
    run_cmp(8'hFF, 8'h00, GT, 8, 1);
    run_cmp(8'h0F, 8'h1F, LT, 8, 4);
    run_cmp(8'h00, 8'h00, EQ, 8, 8);
    hold_start_test();
    reset_abort_test();

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
